// File: rtl/com_pkg.sv
// Shared helpers for the com_var_delay delay line.
//   clog2       : ceiling log2, usable in constant expressions
//   PW, DW      : pointer and delay widths for the default 32-entry line
//   lane_slice  : bit offset of lane c inside a packed multi-lane word
package com_pkg;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v * 2;
         r++;
      end
      return r;
   endfunction

   localparam int MAX_DEPTH_DEF = 32;
   localparam int PW            = clog2(MAX_DEPTH_DEF);
   localparam int DW            = clog2(MAX_DEPTH_DEF + 1);

   function automatic int lane_slice(input int c, input int width = 8);
      return c * width;
   endfunction

endpackage

// File: rtl/com_delay_ram.sv
// Storage array for the delay line: DEPTH entries of DATA_W bits,
// synchronous write, asynchronous read, no reset (maps to SRL/LUTRAM).
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module com_delay_ram #(
   parameter int DEPTH  = 32,
   parameter int DATA_W = 32,
   parameter int PTR_W  = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [PTR_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/com_var_delay.sv
// Runtime-programmable multi-lane delay line with valid tracking and stall.
// A circular buffer advances one entry per enabled cycle; the read pointer
// trails the write pointer by the registered delay. A delay change flushes
// all valid bits so stale data never emerges at the new latency.
//   clk       : clock
//   rst       : asynchronous active-high reset (wptr, vbit, dly_q only)
//   en        : advance; low holds the line and freezes the output
//   dly       : requested delay 0..MAX_DEPTH, larger values clamp
//   in_valid  : qualifier of in_data
//   in_data   : CHANNELS lanes of WIDTH bits
//   out_valid : qualifier of out_data
//   out_data  : delayed lanes, zero whenever out_valid is low
module com_var_delay
   import com_pkg::*;
#(
   parameter  int WIDTH     = 8,
   parameter  int CHANNELS  = 4,
   parameter  int MAX_DEPTH = 32,
   localparam int DLY_W     = clog2(MAX_DEPTH + 1),
   localparam int PTR_W     = clog2(MAX_DEPTH),
   localparam int DATA_W    = CHANNELS * WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DLY_W-1:0]  dly,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   logic [PTR_W-1:0]     wptr;
   logic [PTR_W-1:0]     wptr_nxt;
   logic [PTR_W-1:0]     rptr;
   logic [MAX_DEPTH-1:0] vbit;
   logic [DLY_W-1:0]     dly_q;
   logic [DLY_W-1:0]     dly_c;
   logic                 match;
   logic [DLY_W:0]       wext;
   logic [DLY_W:0]       dext;
   logic [DLY_W:0]       rdiff;
   logic [DATA_W-1:0]    rdata;
   logic [DATA_W-1:0]    src;
   logic                 rd_valid;

   assign dly_c = (dly > DLY_W'(MAX_DEPTH)) ? DLY_W'(MAX_DEPTH) : dly;
   assign match = (dly_c == dly_q);

   assign wptr_nxt = (wptr == PTR_W'(MAX_DEPTH - 1)) ? '0 : wptr + PTR_W'(1);

   // Modulo subtraction that also works for non-power-of-two depths;
   // dly_q == MAX_DEPTH lands on wptr itself (oldest entry).
   assign wext  = (DLY_W + 1)'(wptr);
   assign dext  = (DLY_W + 1)'(dly_q);
   assign rdiff = (dext > wext) ? wext + (DLY_W + 1)'(MAX_DEPTH) - dext
                                : wext - dext;
   assign rptr  = PTR_W'(rdiff);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         vbit  <= '0;
         dly_q <= '0;
      end else begin
         if (!match) begin
            dly_q <= dly_c;
            vbit  <= '0;
         end
         // Later assignment wins, so the write on a flush edge survives.
         if (en) begin
            vbit[wptr] <= in_valid;
            wptr       <= wptr_nxt;
         end
      end
   end

   com_delay_ram #(
      .DEPTH  (MAX_DEPTH),
      .DATA_W (DATA_W),
      .PTR_W  (PTR_W)
   ) u_ram (
      .clk   (clk),
      .we    (en),
      .waddr (wptr),
      .wdata (in_data),
      .raddr (rptr),
      .rdata (rdata)
   );

   assign rd_valid  = (dly_q == '0) ? in_valid : vbit[rptr];
   assign src       = (dly_q == '0) ? in_data : rdata;
   assign out_valid = match & rd_valid;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      assign out_data[lane_slice(c, WIDTH) +: WIDTH] =
         out_valid ? src[lane_slice(c, WIDTH) +: WIDTH] : '0;
   end

endmodule

// File: doc/com_var_delay.md
# com_var_delay

Runtime-programmable, multi-channel delay line with valid tracking and stall support. It aligns parallel data lanes against variable-latency compute in the accelerator datapath, for example matching feature-map pixels to a MAC pipeline whose depth depends on the layer configuration. Storage is a circular buffer with a write pointer; the per-entry valid bits live in resettable flops.

## Interface
- WIDTH, 8, bits per channel
- CHANNELS, 4, number of parallel lanes sharing one valid and one delay setting
- MAX_DEPTH, 32, maximum delay in enabled cycles; must be ≥ 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  advance; when low, the line holds and the output is frozen
- dly  in  DW = clog2(MAX_DEPTH+1)  requested delay, 0..MAX_DEPTH; larger values are clamped to MAX_DEPTH
- in_valid  in  1  qualifier of in_data
- in_data  in  CHANNELS*WIDTH  lane c occupies bits [c*WIDTH +: WIDTH]
- out_valid  out  1  qualifier of out_data
- out_data  out  CHANNELS*WIDTH  delayed lanes; all zero whenever out_valid=0

## Operation
- State:
  - mem[0..MAX_DEPTH-1] holds CHANNELS*WIDTH bits per entry and is not reset.
  - vbit[0..MAX_DEPTH-1] is reset to 0.
  - wptr, 0..MAX_DEPTH-1, is reset to 0.
  - dly_q holds the clamped delay and is reset to 0.
- Write, on an edge with en=1:
  - mem[wptr]<=in_data and vbit[wptr]<=in_valid.
  - wptr<=wptr+1, wrapping from MAX_DEPTH-1 to 0.
- Read is combinational from registered state: rptr=(wptr−dly_q) mod MAX_DEPTH.
- dly_q ≥ 1: out_valid = match & vbit[rptr], and out_data = mem[rptr] when out_valid is high, otherwise 0.
- dly_q = 0: pass-through. out_valid = match & in_valid, out_data = in_data masked by out_valid.
- Match: match = (clamp(dly) == dly_q). A mismatch forces out_valid=0 in that cycle.
- Delay change: on any edge where clamp(dly) ≠ dly_q, regardless of en:
  - dly_q<=clamp(dly) and all vbit are cleared (flush).
  - If en=1 on the same edge, the incoming write still happens: vbit[wptr]<=in_valid survives the flush and wptr advances.
  - After a change to D, out_valid stays 0 until D enabled writes carrying in_valid=1 have been made since the flush.
- Invalid bubbles propagate: an input with in_valid=0 emerges with out_valid=0 and out_data=0.
- en=0 with constant dly: no state changes, and out_valid/out_data are stable.
- A change of dly while en=0 still flushes.

## Timing
- Latency equals dly_q enabled clock edges. With en tied high this is exactly dly_q cycles; dly_q=0 gives a zero-cycle combinational path.
- Throughput is one sample per enabled cycle. There is no backpressure output.
- Reset asserted at any time:
  - wptr=0, vbit=0, dly_q=0 immediately.
  - out_valid and out_data then follow the dly_q=0 pass-through rule. With dly ≠ 0 applied, match=0, so out_valid=0 and out_data=0.
  - The first edge after reset release latches clamp(dly) into dly_q, as a delay change, and flushes.
- Wrap-around is transparent. With dly_q=MAX_DEPTH, rptr==wptr, so the read returns the oldest entry just before it is overwritten.
- Reset is applied only to wptr, vbit and dly_q, never to mem (SRL/BRAM-friendly).

## Structure
- Package com_pkg:
  - function clog2
  - localparams for pointer width PW=clog2(MAX_DEPTH) and delay width DW
  - function lane_slice(c) returning the bit offset
- Sub-module com_delay_ram: a MAX_DEPTH × (CHANNELS*WIDTH) storage array with synchronous write and asynchronous read, with no reset.
- The top level holds wptr, vbit, dly_q, the clamp logic, rptr arithmetic and output masking.

## Test plan
Use WIDTH=8, CHANNELS=4, MAX_DEPTH=32.
1. dly=5 held, en=1, in_valid=1, in_data=counter 0,1,2,… on lane 0 -> out_valid rises 5 cycles after the first write, then out lane 0 = input − 5 every cycle. Before that, out_valid=0 and out_data=0.
2. dly=3, en toggled 1,0,0,1,1,… -> the output advances only on enabled edges. The sample written on enabled edge k appears after enabled edge k+3, and the output is frozen during en=0.
3. Streaming at dly=4, switch to dly=2 mid-stream -> out_valid=0 in the change cycle and the following cycle. It then resumes with samples written after the flush: the sample written on the change edge appears after 2 enabled edges.
4. dly=0 -> out_data=in_data in the same cycle. Set in_valid=0 with in_data=8'hFF on all lanes -> out_valid=0, out_data=0.
5. dly=40 (clamped to 32) and dly=32, long stream of 100 samples -> latency is 32 in both cases, wrap is correct (sample n out at cycle n+32), and no corruption at the pointer wrap.
6. Assert rst asynchronously mid-stream at dly=6, for 1 cycle between edges -> out_valid=0 and out_data=0 immediately. After release, the first valid output comes 6 enabled edges after the first post-reset valid write.
